// File: rtl/ipsxe_floating_point_fx2fl_norm_v1_0_pkg.sv
// Shared single-precision floating-point constants and the packed result layout
// used by the fixed-to-float normaliser and its round-and-pack stage.
package ipsxe_floating_point_fx2fl_norm_v1_0_pkg;

  localparam int FP_WORD_W     = 32;
  localparam int FP_EXP_W      = 8;
  localparam int FP_MANT_W     = 23;
  localparam int FP_EXP_BIAS   = 127;
  // Position of the round (guard) bit and top of the sticky field inside the
  // normalised word once the hidden 1 sits at bit FP_WORD_W-1.
  localparam int FP_GUARD_POS  = FP_WORD_W - 2 - FP_MANT_W;
  localparam int FP_STICKY_MSB = FP_GUARD_POS - 1;

  typedef struct packed {
    logic                 sign;
    logic [FP_EXP_W-1:0]  exp;
    logic [FP_MANT_W-1:0] mant;
  } fp32_t;

endpackage

// File: rtl/ipsxe_floating_point_fx2fl_norm_v1_0_round_pack.sv
// Round-to-nearest-even and field packing of a normalised magnitude.
// Purely combinational; the parent registers the outputs.
module ipsxe_floating_point_round_pack_v1_0
  import ipsxe_floating_point_fx2fl_norm_v1_0_pkg::*;
(
  input  logic                 i_sign,
  input  logic                 i_zero,
  input  logic [FP_WORD_W-1:0] i_norm,
  input  logic [FP_EXP_W-1:0]  i_exp,
  output fp32_t                o_result,
  output logic                 o_inexact
);

  logic [FP_MANT_W-1:0] w_mant;
  logic                 w_guard;
  logic                 w_sticky;
  logic                 w_round_up;
  logic [FP_MANT_W:0]   w_mant_sum;

  // The hidden 1 at the top bit is dropped; the next 23 bits are the fraction.
  assign w_mant     = i_norm[FP_WORD_W-2 -: FP_MANT_W];
  assign w_guard    = i_norm[FP_GUARD_POS];
  assign w_sticky   = |i_norm[FP_STICKY_MSB:0];
  assign w_round_up = w_guard & (w_sticky | w_mant[0]);
  // A carry out of the fraction leaves the low bits all zero, which is exactly
  // the cleared mantissa of the next binade.
  assign w_mant_sum = {1'b0, w_mant} + {{FP_MANT_W{1'b0}}, w_round_up};

  // Pack sign/exponent/mantissa, forcing +0 and exact for a zero input.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    o_result  = '0;
    o_inexact = 1'b0;
    if (!i_zero) begin
      o_result.sign = i_sign;
      o_result.mant = w_mant_sum[FP_MANT_W-1:0];
      o_result.exp  = w_mant_sum[FP_MANT_W] ? i_exp + 8'd1 : i_exp;
      o_inexact     = w_guard | w_sticky;
    end
  end

endmodule

// File: rtl/ipsxe_floating_point_fx2fl_norm_v1_0.sv
// Three-stage normaliser: converts a sign/magnitude integer with a known
// leading-one position into an IEEE-754 single-precision value.
module ipsxe_floating_point_fx2fl_norm_v1_0
  import ipsxe_floating_point_fx2fl_norm_v1_0_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int LOC_BITS = 5,
  parameter int EXP_BIAS = FP_EXP_BIAS
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_aclken,
  input  logic                i_valid,
  input  logic                i_sign,
  input  logic [WIDTH-1:0]    i_mag,
  input  logic [LOC_BITS-1:0] i_one_loc,
  input  logic                i_zero,
  output logic                o_valid,
  output logic [31:0]         o_result,
  output logic                o_inexact
);

  // Stage 1: captured inputs
  logic                r1_valid;
  logic                r1_sign;
  logic [WIDTH-1:0]    r1_mag;
  logic [LOC_BITS-1:0] r1_loc;
  logic                r1_zero;

  // Stage 2: normalised magnitude and biased exponent
  logic                r2_valid;
  logic                r2_sign;
  logic                r2_zero;
  logic [WIDTH-1:0]    r2_norm;
  logic [FP_EXP_W-1:0] r2_exp;

  // Stage 3: registered result
  logic                r3_valid;
  fp32_t               r3_result;
  logic                r3_inexact;

  logic [LOC_BITS-1:0] w_shamt;
  logic [WIDTH-1:0]    w_norm;
  logic [FP_EXP_W-1:0] w_exp;
  fp32_t               w_result;
  logic                w_inexact;

  assign w_shamt = LOC_BITS'(WIDTH - 1) - r1_loc;
  assign w_norm  = r1_mag << w_shamt;
  assign w_exp   = FP_EXP_W'(EXP_BIAS) + FP_EXP_W'(r1_loc);

  // Valid bits: cleared by reset regardless of the clock enable.
  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
    if (i_rst) begin
      r1_valid <= 1'b0;
      r2_valid <= 1'b0;
    end else if (i_aclken) begin
      r1_valid <= i_valid;
      r2_valid <= r1_valid;
    end
  end

  // Stage 1 and 2 data: advance on enable only.
  always_ff @(posedge i_clk) begin
    // NOTE: pipeline data carries no reset; its qualifying valid bit is what reset clears.
    if (i_aclken) begin
      r1_sign <= i_sign;
      r1_mag  <= i_mag;
      r1_loc  <= i_one_loc;
      r1_zero <= i_zero;
      r2_sign <= r1_sign;
      r2_zero <= r1_zero;
      r2_norm <= w_norm;
      r2_exp  <= w_exp;
    end
  end

  ipsxe_floating_point_round_pack_v1_0 u_round_pack (
    .i_sign    (r2_sign),
    .i_zero    (r2_zero),
    .i_norm    (r2_norm),
    .i_exp     (r2_exp),
    .o_result  (w_result),
    .o_inexact (w_inexact)
  );

  // Stage 3: output register, fully cleared by reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r3_valid   <= 1'b0;
      r3_result  <= '0;
      r3_inexact <= 1'b0;
    end else if (i_aclken) begin
      r3_valid   <= r2_valid;
      r3_result  <= w_result;
      r3_inexact <= w_inexact;
    end
  end

  assign o_valid   = r3_valid;
  assign o_result  = r3_result;
  assign o_inexact = r3_inexact;

endmodule

// File: tb/tb_ipsxe_floating_point_fx2fl_norm_v1_0.sv
// Self-checking bench: directed corner vectors, clock-enable and reset
// sequences, then randomized traffic against an arithmetic conversion model.
module tb_ipsxe_floating_point_fx2fl_norm_v1_0;

  logic        clk = 1'b0;
  logic        rst;
  logic        aclken;
  logic        valid;
  logic        sign;
  logic [31:0] mag;
  logic [4:0]  one_loc;
  logic        zero;
  logic        o_valid;
  logic [31:0] o_result;
  logic        o_inexact;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic        valid;
    logic        known;
    logic [31:0] result;
    logic        inexact;
  } exp_t;

  // Expected content of each pipeline position; index 2 is what the outputs show.
  exp_t pipe [3];

  ipsxe_floating_point_fx2fl_norm_v1_0 dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_aclken  (aclken),
    .i_valid   (valid),
    .i_sign    (sign),
    .i_mag     (mag),
    .i_one_loc (one_loc),
    .i_zero    (zero),
    .o_valid   (o_valid),
    .o_result  (o_result),
    .o_inexact (o_inexact)
  );

  always #5 clk = ~clk;

  function automatic int msb_of(input logic [31:0] m);
    int p = 0;
    for (int i = 0; i < 32; i++) if (m[i]) p = i;
    return p;
  endfunction

  // Integer-to-float by plain arithmetic: quotient/remainder rounding.
  function automatic exp_t ref_conv(input logic s, input logic [31:0] m, input logic z,
                                    input logic v);
    exp_t        r;
    int          p;
    int          e;
    int          sh;
    logic [63:0] q;
    logic [63:0] rem;
    logic [63:0] half;
    r.valid = v;
    r.known = 1'b1;
    r.result = 32'h0;
    r.inexact = 1'b0;
    if (!z) begin
      p = msb_of(m);
      e = 127 + p;
      if (p <= 23) begin
        q = 64'(m) << (23 - p);
      end else begin
        sh   = p - 23;
        q    = 64'(m) >> sh;
        rem  = 64'(m) - (q << sh);
        half = 64'd1 << (sh - 1);
        if (rem > half || (rem == half && q[0])) q = q + 1;
        if (q == (64'd1 << 24)) begin
          q = q >> 1;
          e = e + 1;
        end
        r.inexact = (rem != 0);
      end
      r.result = {s, 8'(e), q[22:0]};
    end
    return r;
  endfunction

  // Apply one cycle of stimulus, advance the model, then compare after the edge.
  task automatic step(input logic r, input logic en, input logic v, input logic s,
                      input logic z, input logic [31:0] m);
    exp_t nx;
    rst     = r;
    aclken  = en;
    valid   = v;
    sign    = s;
    zero    = z;
    mag     = z ? 32'h0 : m;
    one_loc = z ? 5'($urandom_range(0, 31)) : 5'(msb_of(m));
    nx = ref_conv(s, z ? 32'h0 : m, z, v);
    @(posedge clk);
    #1;
    if (r) begin
      pipe[0].valid = 1'b0; pipe[0].known = 1'b0;
      pipe[1].valid = 1'b0; pipe[1].known = 1'b0;
      pipe[2].valid = 1'b0; pipe[2].known = 1'b1;
      pipe[2].result = 32'h0; pipe[2].inexact = 1'b0;
    end else if (en) begin
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      pipe[0] = nx;
    end
    n_vec++;
    assert (o_valid === pipe[2].valid) else begin
      n_err++;
      $error("FAIL o_valid observed=%0b expected=%0b at %0t", o_valid, pipe[2].valid, $time);
    end
    if (pipe[2].known) begin
      n_vec++;
      assert (o_result === pipe[2].result) else begin
        n_err++;
        $error("FAIL o_result observed=%h expected=%h at %0t", o_result, pipe[2].result, $time);
      end
      n_vec++;
      assert (o_inexact === pipe[2].inexact) else begin
        n_err++;
        $error("FAIL o_inexact observed=%0b expected=%0b at %0t", o_inexact, pipe[2].inexact, $time);
      end
    end
  endtask

  function automatic logic [31:0] rand_mag();
    int          p;
    int          sh;
    logic [31:0] m;
    logic [31:0] mask;
    p = $urandom_range(0, 31);
    m = ($urandom() | 32'h8000_0000) >> (31 - p);
    // Force an exact rounding tie now and then when bits are discarded.
    if (p > 24 && $urandom_range(0, 3) == 0) begin
      sh   = p - 23;
      mask = (32'h1 << sh) - 1;
      m    = (m & ~mask) | (32'h1 << (sh - 1));
    end
    return m;
  endfunction

  initial begin
    rst = 1'b1; aclken = 1'b0; valid = 1'b0; sign = 1'b0;
    mag = 32'h0; one_loc = 5'd0; zero = 1'b1;
    foreach (pipe[i]) begin
      pipe[i].valid = 1'b0; pipe[i].known = 1'b0;
      pipe[i].result = 32'h0; pipe[i].inexact = 1'b0;
    end

    // Reset with the enable low still clears the outputs.
    step(1, 0, 0, 0, 1, 0);
    step(1, 1, 0, 0, 1, 0);

    // Directed corner vectors, back to back, then flush with zero bubbles.
    step(0, 1, 1, 0, 0, 32'h0000_0001);
    step(0, 1, 1, 1, 0, 32'h8000_0000);
    step(0, 1, 1, 0, 0, 32'h0100_0001);
    step(0, 1, 1, 0, 0, 32'h0100_0003);
    step(0, 1, 1, 0, 0, 32'hFFFF_FFFF);
    step(0, 1, 1, 1, 1, 32'h0);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 1, 32'h0);

    // Valid stream with the enable alternating each cycle.
    for (int i = 0; i < 16; i++) step(0, (i % 2) == 0, 1, i[0], 0, rand_mag());
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 1, 32'h0);

    // Two words in flight, then reset (enable low) and idle: nothing may emerge.
    step(0, 1, 1, 0, 0, 32'h1234_5678);
    step(0, 1, 1, 1, 0, 32'h0000_00FF);
    step(1, 0, 0, 0, 1, 32'h0);
    for (int i = 0; i < 5; i++) step(0, 1, 0, 0, 1, 32'h0);

    // Randomized traffic with enable gaps, zeros and occasional resets.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 49) == 0, $urandom_range(0, 3) != 0, 1'($urandom),
           1'($urandom), $urandom_range(0, 9) == 0, rand_mag());
    end
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 1, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
